// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {StIdle, StGrant} arb_state_e;

  localparam int unsigned DefNreq     = 4;
  localparam int unsigned DefMaxBurst = 16;
  localparam int unsigned DefIdleTmo  = 64;

  // Burst and idle counters only need to reach 255.
  localparam int unsigned CntW     = 8;
  localparam int unsigned ByteCntW = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester pick: first active request after i_last, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last,
  output logic [$clog2(NREQ)-1:0] o_grant,
  output logic                    o_any
);

  localparam int unsigned IdW = $clog2(NREQ);

  always_comb begin
    int unsigned      idx;
    logic [IdW-1:0]   sel;
    o_grant = i_last;
    o_any   = |i_req;
    idx     = 0;
    sel     = '0;
    // Walk farthest-first so the nearest active requester wins.
    for (int unsigned k = NREQ; k != 0; k--) begin
      idx = (32'(i_last) + k) % NREQ;
      sel = IdW'(idx);
      if (i_req[sel]) o_grant = sel;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte streams onto one UART transmit stream with burst cap and idle timeout.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ      = DefNreq,
  parameter int unsigned MAX_BURST = DefMaxBurst,
  parameter int unsigned IDLE_TMO  = DefIdleTmo
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              tx_tdata,
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [ByteCntW-1:0]     byte_count
);

  localparam int unsigned     IdW       = $clog2(NREQ);
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);
  localparam logic [CntW-1:0] IdleLast  = CntW'(IDLE_TMO - 1);

  arb_state_e           r_state, w_state_nxt;
  logic [IdW-1:0]       r_grant_id, w_pick;
  logic [CntW-1:0]      r_burst_cnt, r_idle_cnt;
  logic [7:0]           r_tdata, w_gdata;
  logic                 r_tvalid;
  logic [ByteCntW-1:0]  r_byte_cnt;
  logic                 w_any, w_slot, w_xfer, w_gvalid, w_glast, w_granted;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .i_req  (req_valid),
    .i_last (r_grant_id),
    .o_grant(w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_gvalid  = req_valid[r_grant_id];
    w_glast   = req_last[r_grant_id];
    w_gdata   = req_data[{r_grant_id, 3'b000} +: 8];
    w_granted = rst_n && (r_state == StGrant);
    // Output register can take a byte when empty or draining this cycle.
    w_slot    = !r_tvalid || tx_tready;
    w_xfer    = w_granted && w_gvalid && w_slot;
    req_ready = '0;
    if (w_granted) req_ready[r_grant_id] = w_slot;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_any) w_state_nxt = StGrant;
      end
      StGrant: begin
        if (w_xfer && (w_glast || r_burst_cnt == BurstLast)) begin
          w_state_nxt = StIdle;
        end else if (!w_gvalid && r_idle_cnt == IdleLast) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_grant_id  <= IdW'(NREQ - 1);
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_byte_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle && w_any) begin
        r_grant_id  <= w_pick;
        r_burst_cnt <= '0;
        r_idle_cnt  <= '0;
      end else if (r_state == StGrant) begin
        if (w_xfer) begin
          r_burst_cnt <= r_burst_cnt + CntW'(1);
          r_idle_cnt  <= '0;
        end else if (!w_gvalid) begin
          r_idle_cnt <= r_idle_cnt + CntW'(1);
        end
      end
      // Load wins over drain so a simultaneous load/drain has no bubble.
      if (w_xfer) begin
        r_tdata  <= w_gdata;
        r_tvalid <= 1'b1;
      end else if (tx_tready) begin
        r_tvalid <= 1'b0;
      end
      if (r_tvalid && tx_tready) r_byte_cnt <= r_byte_cnt + ByteCntW'(1);
    end
  end

  assign tx_tdata   = r_tdata;
  assign tx_tvalid  = r_tvalid;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state == StGrant);
  assign byte_count = r_byte_cnt;

endmodule
